// File: rtl/qbus_pkg.sv
// Shared Qbus definitions: master FSM states, IO-page decode,
// and the register addresses shared with the slave block.
package qbus_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_REQ,
    ST_GRANT,
    ST_ADDR,
    ST_SYNC,
    ST_DATA,
    ST_WAIT,
    ST_RNEG,
    ST_REL,
    ST_DONE
  } qdm_state_t;

  localparam logic [8:0] IOPAGE_HI = 9'h1FF;

  localparam logic [21:0] QADDR_CSR  = 22'o17772150;
  localparam logic [21:0] QADDR_DATA = 22'o17772152;
  localparam logic [21:0] QADDR_ADRL = 22'o17772154;
  localparam logic [21:0] QADDR_ADRH = 22'o17772156;

  function automatic logic is_iopage(input logic [21:0] a);
    return a[21:13] == IOPAGE_HI;
  endfunction

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/qbus_dma_master_sync.sv
// N-bit multi-stage synchroniser for asynchronous Qbus receivers.
// Reset loads INIT so active-low lines come up negated.
module qbus_sync #(
  parameter int         N      = 1,
  parameter int         STAGES = 2,
  parameter logic [N-1:0] INIT = '1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] ff [STAGES];

  // shift the raw inputs through the flop chain
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) ff[i] <= INIT;
    end else begin
      ff[0] <= d;
      for (int i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/qbus_dma_master.sv
// Qbus bus-master sequencer: one arbitrated DATI/DATO(B)
// cycle per command, with timeout abort (NXM).
module qbus_dma_master
  import qbus_pkg::*;
#(
  parameter int ADDR_SETUP  = 15,
  parameter int ADDR_HOLD   = 10,
  parameter int DATA_SETUP  = 10,
  parameter int RPLY_DESKEW = 20,
  parameter int TIMEOUT     = 1000,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic        cmd_byte,
  input  logic [21:0] cmd_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_done,
  output logic        rsp_nxm,
  output logic [15:0] rsp_rdata,
  input  logic [21:0] BDALf_IN,
  output logic [21:0] BDALf_OUT,
  output logic [21:0] BDALf_OE,
  output logic        Outbound,
  input  logic        BRPLYf,
  input  logic        BDMGIf,
  input  logic        BSYNCf,
  input  logic        BINITf,
  output logic        BSYNCg,
  output logic        BDINg,
  output logic        BDOUTg,
  output logic        BWTBTg,
  output logic        BBS7g,
  output logic        BDMRg,
  output logic        BSACKg,
  output logic        BDMGOg
);

  localparam int MAXP = max_of(max_of(max_of(ADDR_SETUP, ADDR_HOLD),
                               max_of(DATA_SETUP, RPLY_DESKEW)), TIMEOUT);
  localparam int CW = $clog2(MAXP) + 1;

  logic [3:0] raw_in;
  logic [3:0] sync_in;
  logic       rply;
  logic       dmgi;
  logic       bsync_in;
  logic       binit;

  assign raw_in = {BRPLYf, BDMGIf, BSYNCf, BINITf};

  qbus_sync #(
    .N      (4),
    .STAGES (SYNC_STAGES),
    .INIT   (4'hF)
  ) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (raw_in),
    .q     (sync_in)
  );

  assign rply     = ~sync_in[3];
  assign dmgi     = ~sync_in[2];
  assign bsync_in = ~sync_in[1];
  assign binit    = ~sync_in[0];

  qdm_state_t  state;
  logic [CW-1:0] cnt;
  logic        expired;
  logic        seen;
  logic        nxm;
  logic        c_write;
  logic        c_byte;
  logic [21:0] c_addr;
  logic [15:0] c_wdata;
  logic        unused_bdal;

  assign unused_bdal = ^BDALf_IN[21:16];
  assign expired     = (cnt <= CW'(1));
  assign cmd_ready   = (state == ST_IDLE);
  assign BDMGOg      = dmgi && (state == ST_IDLE) && !cmd_valid;

  // bus-master sequencer with registered Qbus and response outputs
  always_ff @(posedge clock) begin
    if (reset || binit) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      seen      <= 1'b0;
      nxm       <= 1'b0;
      c_write   <= 1'b0;
      c_byte    <= 1'b0;
      c_addr    <= '0;
      c_wdata   <= '0;
      BDALf_OUT <= '0;
      BDALf_OE  <= '0;
      Outbound  <= 1'b0;
      BSYNCg    <= 1'b0;
      BDINg     <= 1'b0;
      BDOUTg    <= 1'b0;
      BWTBTg    <= 1'b0;
      BBS7g     <= 1'b0;
      BDMRg     <= 1'b0;
      BSACKg    <= 1'b0;
      rsp_done  <= 1'b0;
      rsp_nxm   <= 1'b0;
      if (reset) rsp_rdata <= '0;
    end else begin
      rsp_done <= 1'b0;
      rsp_nxm  <= 1'b0;
      if (cnt != '0) cnt <= cnt - CW'(1);
      unique case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            c_write <= cmd_write;
            c_byte  <= cmd_byte;
            c_addr  <= cmd_addr;
            c_wdata <= cmd_wdata;
            nxm     <= 1'b0;
            BDMRg   <= 1'b1;
            cnt     <= CW'(TIMEOUT);
            state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (dmgi && !bsync_in && !rply) begin
            BDMRg  <= 1'b0;
            BSACKg <= 1'b1;
            state  <= ST_GRANT;
          end else if (expired) begin
            BDMRg    <= 1'b0;
            nxm      <= 1'b1;
            rsp_done <= 1'b1;
            rsp_nxm  <= 1'b1;
            state    <= ST_DONE;
          end
        end
        ST_GRANT: begin
          BDALf_OUT <= c_addr;
          BDALf_OE  <= '1;
          Outbound  <= 1'b1;
          BBS7g     <= is_iopage(c_addr);
          BWTBTg    <= c_write;
          cnt       <= CW'(ADDR_SETUP);
          state     <= ST_ADDR;
        end
        ST_ADDR: begin
          if (expired) begin
            BSYNCg <= 1'b1;
            cnt    <= CW'(ADDR_HOLD);
            state  <= ST_SYNC;
          end
        end
        ST_SYNC: begin
          if (expired) begin
            BBS7g <= 1'b0;
            state <= ST_DATA;
            if (c_write) begin
              BDALf_OUT <= {6'b0, c_wdata};
              BDALf_OE  <= '1;
              Outbound  <= 1'b1;
              BWTBTg    <= c_byte;
              cnt       <= CW'(DATA_SETUP);
            end else begin
              BDALf_OUT <= '0;
              BDALf_OE  <= '0;
              Outbound  <= 1'b0;
              BDINg     <= 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (!c_write || expired) begin
            if (c_write) BDOUTg <= 1'b1;
            seen  <= 1'b0;
            cnt   <= CW'(TIMEOUT);
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!seen) begin
            if (rply) begin
              seen <= 1'b1;
              cnt  <= CW'(RPLY_DESKEW);
            end else if (expired) begin
              nxm    <= 1'b1;
              BDINg  <= 1'b0;
              BDOUTg <= 1'b0;
              cnt    <= CW'(TIMEOUT);
              state  <= ST_RNEG;
            end
          end else if (expired) begin
            if (!c_write) rsp_rdata <= ~BDALf_IN[15:0];
            BDINg  <= 1'b0;
            BDOUTg <= 1'b0;
            cnt    <= CW'(TIMEOUT);
            state  <= ST_RNEG;
          end
        end
        ST_RNEG: begin
          if (!rply || expired) begin
            if (rply) nxm <= 1'b1;
            BSYNCg    <= 1'b0;
            BWTBTg    <= 1'b0;
            BDALf_OUT <= '0;
            BDALf_OE  <= '0;
            Outbound  <= 1'b0;
            state     <= ST_REL;
          end
        end
        ST_REL: begin
          BSACKg   <= 1'b0;
          rsp_done <= 1'b1;
          rsp_nxm  <= nxm;
          state    <= ST_DONE;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
